iot_event_scheduler: RTL and testbench

IOT_EVENT_SCHEDULER -- requirements
Module: iot_event_scheduler

---
 rtl/iot_event_scheduler_pkg.sv | 33 +++
 rtl/iot_event_scheduler_rr_arbiter.sv | 44 ++++
 rtl/iot_event_scheduler.sv | 108 ++++++++++
 tb/tb_iot_event_scheduler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/iot_event_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// iot_pkg
//   Shared definitions for the IoT event scheduler and the downstream
//   device-count monitor that consumes its change/on_off event stream.
//   Contents:
//     N_DEV_DEFAULT - default number of monitored devices
//     dir_e         - direction encoding of one count event
//     pend_dir()    - turns a device's pending flag pair into a direction
// ---------------------------------------------------------------------------
package iot_pkg;

    localparam int N_DEV_DEFAULT = 8;

    typedef enum logic [1:0] {
        DIR_HOLD = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_e;

    // The flag pair is never 2'b11; up takes precedence defensively.
    function automatic dir_e pend_dir(input logic up, input logic dn);
        dir_e d;
        if (up) begin
            d = DIR_UP;
        end else if (dn) begin
            d = DIR_DOWN;
        end else begin
            d = DIR_HOLD;
        end
        return d;
    endfunction

endpackage

// File: rtl/iot_event_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker: grants the lowest index at or
//   above ptr (wrapping modulo N_DEV) whose request bit is set.
//   Ports:
//     req       in  [N_DEV-1:0] request vector, one bit per device
//     ptr       in  [PW-1:0]    index where the search starts
//     gnt_valid out             at least one request present
//     gnt_idx   out [PW-1:0]    granted index (0 when gnt_valid = 0)
// ---------------------------------------------------------------------------
module rr_arbiter
    import iot_pkg::*;
#(
    parameter int N_DEV = N_DEV_DEFAULT,
    localparam int PW   = (N_DEV > 1) ? $clog2(N_DEV) : 1
) (
    input  logic [N_DEV-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic             gnt_valid,
    output logic [PW-1:0]    gnt_idx
);

    // One extra bit so ptr + offset never overflows before wrapping.
    logic [PW:0] w_idx;

    // Walk offsets from highest to lowest so the smallest offset from ptr
    // is the last one to write the result and therefore wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        w_idx     = '0;
        for (int k = N_DEV - 1; k >= 0; k--) begin
            w_idx = {1'b0, ptr} + (PW+1)'(k);
            if (w_idx >= (PW+1)'(N_DEV)) begin
                w_idx = w_idx - (PW+1)'(N_DEV);
            end
            if (req[w_idx[PW-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = w_idx[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/iot_event_scheduler.sv
// ---------------------------------------------------------------------------
// iot_event_scheduler
//   Watches N_DEV device activity levels, turns every edge into a pending
//   count event and serialises those events, one per cycle, onto a single
//   change/on_off pair feeding an up/down device-count monitor.
//   Ports:
//     clk        in             sole clock, rising edge
//     rst        in             synchronous active-high reset
//     dev_status in [N_DEV-1:0] 1 = device active
//     change     out            registered, 1 = an event is presented
//     on_off     out            registered, 1 = count up, 0 = count down
//     busy       out            registered, 1 = events still pending
// ---------------------------------------------------------------------------
module iot_event_scheduler
    import iot_pkg::*;
#(
    parameter int N_DEV = N_DEV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] dev_status,
    output logic             change,
    output logic             on_off,
    output logic             busy
);

    localparam int PW = (N_DEV > 1) ? $clog2(N_DEV) : 1;

    logic [N_DEV-1:0] r_prev;
    logic [N_DEV-1:0] r_pend_up;
    logic [N_DEV-1:0] r_pend_dn;
    logic [PW-1:0]    r_ptr;
    logic             r_change;
    logic             r_on_off;
    logic             r_busy;

    logic [N_DEV-1:0] w_rise;
    logic [N_DEV-1:0] w_fall;
    logic [N_DEV-1:0] w_gnt_hot;
    logic [N_DEV-1:0] w_pend_up_next;
    logic [N_DEV-1:0] w_pend_dn_next;
    logic             w_gnt_valid;
    logic [PW-1:0]    w_gnt_idx;
    dir_e             w_gnt_dir;

    assign w_rise = dev_status & ~r_prev;
    assign w_fall = ~dev_status & r_prev;

    rr_arbiter #(
        .N_DEV (N_DEV)
    ) u_arb (
        .req       (r_pend_up | r_pend_dn),
        .ptr       (r_ptr),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    assign w_gnt_dir = pend_dir(r_pend_up[w_gnt_idx], r_pend_dn[w_gnt_idx]);

    generate
        for (genvar gi = 0; gi < N_DEV; gi++) begin : g_dev
            assign w_gnt_hot[gi] = w_gnt_valid && (w_gnt_idx == PW'(gi));

            // A granted device has its old flag consumed this edge, so a
            // transition seen at the same edge starts a fresh flag instead
            // of cancelling. Otherwise an opposite transition cancels the
            // outstanding flag (net zero) and a new one sets its own flag.
            assign w_pend_up_next[gi] = w_gnt_hot[gi] ? w_rise[gi]
                : ((r_pend_up[gi] & ~w_fall[gi]) | (w_rise[gi] & ~r_pend_dn[gi]));
            assign w_pend_dn_next[gi] = w_gnt_hot[gi] ? w_fall[gi]
                : ((r_pend_dn[gi] & ~w_rise[gi]) | (w_fall[gi] & ~r_pend_up[gi]));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev    <= '0;
            r_pend_up <= '0;
            r_pend_dn <= '0;
            r_ptr     <= '0;
            r_change  <= 1'b0;
            r_on_off  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_prev    <= dev_status;
            r_pend_up <= w_pend_up_next;
            r_pend_dn <= w_pend_dn_next;
            r_busy    <= |(w_pend_up_next | w_pend_dn_next);
            if (w_gnt_valid) begin
                r_change <= 1'b1;
                r_on_off <= (w_gnt_dir == DIR_UP);
                if (w_gnt_idx == PW'(N_DEV - 1)) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= w_gnt_idx + PW'(1);
                end
            end else begin
                r_change <= 1'b0;
                r_on_off <= 1'b0;
            end
        end
    end

    assign change = r_change;
    assign on_off = r_on_off;
    assign busy   = r_busy;

endmodule

// File: tb/tb_iot_event_scheduler.sv
// ---------------------------------------------------------------------------
// tb_iot_event_scheduler
//   Directed bench for iot_event_scheduler (N_DEV = 8). A per-device signed
//   "owed count" model predicts change/on_off/busy every cycle; directed
//   scenarios add literal expectations on timing and event totals.
// ---------------------------------------------------------------------------
module tb_iot_event_scheduler;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] dev_status;
    logic         change;
    logic         on_off;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;
    int dut_ups = 0;
    int dut_dns = 0;

    iot_event_scheduler #(
        .N_DEV (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dev_status (dev_status),
        .change     (change),
        .on_off     (on_off),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Inputs change and literal checks happen 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_counts();
        dut_ups = 0;
        dut_dns = 0;
    endtask

    // ---------------- behavioural model ----------------
    // owed[i]: net count change still to be reported for device i
    // (+1 = one up owed, -1 = one down owed, 0 = nothing).
    int owed [N];
    int seen [N];
    int m_ptr;
    int g;
    int d;
    bit exp_change;
    bit exp_on_off;
    bit exp_busy;
    bit model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                owed[i] = 0;
                seen[i] = 0;
            end
            m_ptr       = 0;
            exp_change  = 1'b0;
            exp_on_off  = 1'b0;
            exp_busy    = 1'b0;
            model_valid = 1'b1;
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && owed[(m_ptr + k) % N] != 0) g = (m_ptr + k) % N;
            end
            if (g >= 0) begin
                exp_change = 1'b1;
                exp_on_off = (owed[g] > 0);
                m_ptr      = (g + 1) % N;
            end else begin
                exp_change = 1'b0;
                exp_on_off = 1'b0;
            end
            exp_busy = 1'b0;
            for (int i = 0; i < N; i++) begin
                d = int'(dev_status[i]) - seen[i];
                seen[i] = int'(dev_status[i]);
                if (i == g) owed[i] = d;
                else owed[i] = owed[i] + d;
                if (owed[i] != 0) exp_busy = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_valid) begin
            chk("cyc_change", int'(change), int'(exp_change));
            chk("cyc_on_off", int'(on_off), int'(exp_on_off));
            chk("cyc_busy",   int'(busy),   int'(exp_busy));
        end
        if (change === 1'b1) begin
            if (on_off) dut_ups++;
            else dut_dns++;
        end
    end

    // ---------------- directed stimulus ----------------
    logic [N-1:0] mask;

    initial begin
        rst        = 1'b1;
        dev_status = '0;
        repeat (3) step();
        rst = 1'b0;

        // Idle after reset
        for (int c = 0; c < 10; c++) begin
            step();
            chk("idle_change", int'(change), 0);
            chk("idle_busy",   int'(busy),   0);
        end
        $display("txn idle: 10 cycles, no events");

        // Single rise then single fall: event two edges after the change
        dev_status = 8'h01;
        step();
        chk("up1_e1_change", int'(change), 0);
        chk("up1_e1_busy",   int'(busy),   1);
        step();
        chk("up1_e2_change", int'(change), 1);
        chk("up1_e2_on_off", int'(on_off), 1);
        chk("up1_e2_busy",   int'(busy),   0);
        step();
        chk("up1_e3_change", int'(change), 0);
        dev_status = 8'h00;
        step();
        chk("dn1_e1_change", int'(change), 0);
        step();
        chk("dn1_e2_change", int'(change), 1);
        chk("dn1_e2_on_off", int'(on_off), 0);
        step();
        chk("dn1_e3_change", int'(change), 0);
        $display("txn single: dev0 up then down");

        // All devices rise at once: eight back-to-back up events
        clear_counts();
        dev_status = 8'hFF;
        step();
        chk("all_e1_change", int'(change), 0);
        chk("all_e1_busy",   int'(busy),   1);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("all_burst_change", int'(change), 1);
            chk("all_burst_on_off", int'(on_off), 1);
            chk("all_burst_busy",   int'(busy),   (k < 8) ? 1 : 0);
        end
        step();
        chk("all_after_change", int'(change), 0);
        chk("all_ups", dut_ups, 8);
        chk("all_dns", dut_dns, 0);
        $display("txn burst: ups=%0d dns=%0d", dut_ups, dut_dns);

        // Device 3 pulses while the other seven are queued: cancels out
        dev_status = 8'h00;
        repeat (12) step();
        clear_counts();
        dev_status = 8'hF7;
        step();
        dev_status = 8'hFF;
        step();
        dev_status = 8'hF7;
        repeat (12) step();
        chk("cancel_ups",  dut_ups, 7);
        chk("cancel_dns",  dut_dns, 0);
        chk("cancel_busy", int'(busy), 0);
        $display("txn cancel: ups=%0d dns=%0d", dut_ups, dut_dns);

        // Devices active through reset release, reset during second event
        rst        = 1'b1;
        dev_status = 8'h05;
        step();
        step();
        rst = 1'b0;
        clear_counts();
        step();
        chk("rr_e1_change", int'(change), 0);
        chk("rr_e1_busy",   int'(busy),   1);
        step();
        chk("rr_e2_change", int'(change), 1);
        chk("rr_e2_on_off", int'(on_off), 1);
        rst = 1'b1;
        step();
        chk("rr_rst_change", int'(change), 0);
        chk("rr_rst_busy",   int'(busy),   0);
        dev_status = 8'h00;
        step();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("rr_quiet_change", int'(change), 0);
        end
        chk("rr_ups", dut_ups, 1);
        $display("txn reset_mid: ups=%0d dns=%0d", dut_ups, dut_dns);

        // Random toggling then quiescence: net count equals active devices
        clear_counts();
        for (int c = 0; c < 1000; c++) begin
            mask = N'($urandom & $urandom & $urandom);
            dev_status = dev_status ^ mask;
            step();
        end
        repeat (20) step();
        chk("rand_busy", int'(busy), 0);
        chk("rand_net", dut_ups - dut_dns, $countones(dev_status));
        $display("txn random: ups=%0d dns=%0d status=%h", dut_ups, dut_dns, dev_status);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
